psx_port_scheduler: RTL and testbench

Two-port PlayStation pad poller that shares one serial pad bus (psx_clk, cmd, data, ack) between two controller ports, each selected by its own attention line. It runs a built-in bit/byte shift engine and sequences the standard 5-byte poll transaction. It arbitrates round-robin between the enabled ports and publishes per-port button state, connection status and update strobes. It sits between the pad connectors and game logic, and supersedes single-port polling where two pads are fitted.

---
 rtl/psx_port_scheduler_if.sv | 17 +
 rtl/psx_port_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_psx_port_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psx_port_scheduler_if.sv
// Pad-bus bundle shared by both controller ports.
//   psx_clk : serial clock to pads (idle high)
//   cmd     : console-to-pad data, LSB first
//   att     : active-low attention, att[p] selects port p
//   data    : pad-to-console data
//   ack     : pad acknowledge, active low
// master = scheduler side, slave = pad side.
interface psx_port_scheduler_if;
  logic       psx_clk;
  logic       cmd;
  logic [1:0] att;
  logic       data;
  logic       ack;

  modport master (output psx_clk, cmd, att, input data, ack);
  modport slave  (input psx_clk, cmd, att, output data, ack);
endinterface

// File: rtl/psx_port_scheduler.sv
// Two-port PlayStation pad poller. Runs the 5-byte poll (01 42 00 00 00)
// on one shared serial bus, alternating round-robin between enabled ports.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_enable[1:0]         : per-port poll enable, looked at only when choosing a port
//   pad                   : pad bus (psx_clk, cmd, att out; data, ack in)
//   o_button_state_0/1    : {byte3, byte4}, active-low buttons, 16'hffff when invalid
//   o_connected[1:0]      : last transaction on port p succeeded
//   o_update[1:0]         : 1-cycle pulse when port p button state refreshes
module psx_port_scheduler #(
  parameter int BOOT_TIME   = 4000000,
  parameter int HALF_BIT    = 4,
  parameter int ATT_SETUP   = 40,
  parameter int ACK_TIMEOUT = 120,
  parameter int BYTE_GAP    = 14,
  parameter int PORT_GAP    = 250
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [1:0]                  i_enable,
  psx_port_scheduler_if.master        pad,
  output logic [15:0]                 o_button_state_0,
  output logic [15:0]                 o_button_state_1,
  output logic [1:0]                  o_connected,
  output logic [1:0]                  o_update
);
  typedef enum logic [2:0] {
    S_BOOT, S_SELECT, S_ATT_SETUP, S_SHIFT,
    S_WAIT_ACK, S_BYTE_GAP, S_RELEASE, S_PORT_GAP
  } state_e;

  localparam logic [31:0] BOOT_LAST  = 32'(BOOT_TIME - 1);
  localparam logic [31:0] SETUP_LAST = 32'(ATT_SETUP - 1);
  localparam logic [31:0] HALF_LAST  = 32'(HALF_BIT - 1);
  localparam logic [31:0] BIT_LAST   = 32'(2 * HALF_BIT - 1);
  localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] BGAP_LAST  = 32'(BYTE_GAP - 1);
  localparam logic [31:0] PGAP_LAST  = 32'(PORT_GAP - 1);

  state_e           r_state, w_state_nxt;
  logic [31:0]      r_cnt;
  logic [2:0]       r_bit, r_byte;
  logic [7:0]       r_rx, r_b3;
  logic             r_port, r_last;
  logic             r_psx_clk, r_cmd;
  logic [1:0]       r_att, r_conn, r_upd;
  logic [1:0][15:0] r_btn;

  logic       w_half, w_full, w_byte_end, w_bad_sync, w_pick;
  logic [2:0] w_nbit, w_nbyte;
  logic [7:0] w_cmd_byte;
  logic       w_grant, w_clk_fall, w_clk_rise, w_success, w_abort;

  function automatic logic [7:0] f_cmd(input logic [2:0] idx);
    f_cmd = (idx == 3'd0) ? 8'h01 : (idx == 3'd1) ? 8'h42 : 8'h00;
  endfunction

  // r_cnt restarts at every state change and at every bit boundary in SHIFT,
  // so within a bit: cnt==HALF_LAST is the rising edge, cnt==BIT_LAST the bit end.
  assign w_half     = (r_cnt == HALF_LAST);
  assign w_full     = (r_cnt == BIT_LAST);
  assign w_byte_end = w_full && (r_bit == 3'd7);
  assign w_bad_sync = (r_byte == 3'd2) && (r_rx != 8'h5A);
  // Round-robin: take the other port when it is enabled, else stay.
  assign w_pick     = i_enable[~r_last] ? ~r_last : r_last;

  // Byte/bit that the next psx_clk fall will put on cmd.
  assign w_nbyte    = (r_state == S_BYTE_GAP) ? r_byte + 3'd1 :
                      (r_state == S_SHIFT)    ? r_byte : 3'd0;
  assign w_nbit     = (r_state == S_SHIFT) ? r_bit + 3'd1 : 3'd0;
  assign w_cmd_byte = f_cmd(w_nbyte);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:      if (r_cnt == BOOT_LAST) w_state_nxt = S_SELECT;
      S_SELECT:    w_state_nxt = (|i_enable) ? S_ATT_SETUP : S_PORT_GAP;
      S_ATT_SETUP: if (r_cnt == SETUP_LAST) w_state_nxt = S_SHIFT;
      S_SHIFT:     if (w_byte_end)
                     w_state_nxt = (r_byte == 3'd4 || w_bad_sync) ? S_RELEASE : S_WAIT_ACK;
      S_WAIT_ACK:  if (!pad.ack)                w_state_nxt = S_BYTE_GAP;
                   else if (r_cnt == ACK_LAST)  w_state_nxt = S_RELEASE;
      S_BYTE_GAP:  if (r_cnt == BGAP_LAST) w_state_nxt = S_SHIFT;
      S_RELEASE:   w_state_nxt = S_PORT_GAP;
      S_PORT_GAP:  if (r_cnt == PGAP_LAST) w_state_nxt = S_SELECT;
      default:     w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    w_grant    = 1'b0;
    w_clk_fall = 1'b0;
    w_clk_rise = 1'b0;
    w_success  = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_SELECT:    w_grant    = |i_enable;
      S_ATT_SETUP: w_clk_fall = (r_cnt == SETUP_LAST);
      S_SHIFT: begin
        w_clk_rise = w_half;
        w_clk_fall = w_full && (r_bit != 3'd7);
        w_success  = w_byte_end && (r_byte == 3'd4);
        w_abort    = w_byte_end && w_bad_sync;
      end
      S_WAIT_ACK:  w_abort    = pad.ack && (r_cnt == ACK_LAST);
      S_BYTE_GAP:  w_clk_fall = (r_cnt == BGAP_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_rx      <= '0;
      r_b3      <= '0;
      r_port    <= 1'b0;
      r_last    <= 1'b1;   // port 0 goes first after reset
      r_psx_clk <= 1'b1;
      r_cmd     <= 1'b1;
      r_att     <= 2'b11;
      r_conn    <= 2'b00;
      r_upd     <= 2'b00;
      r_btn     <= {2{16'hffff}};
    end else begin
      r_upd <= 2'b00;
      if (w_state_nxt != r_state || (r_state == S_SHIFT && w_full)) r_cnt <= '0;
      else                                                          r_cnt <= r_cnt + 32'd1;

      if (r_state == S_SELECT) begin
        r_conn <= r_conn & i_enable;   // disabled ports lose connected, buttons hold
        if (w_grant) begin
          r_port        <= w_pick;
          r_last        <= w_pick;
          r_att[w_pick] <= 1'b0;
        end
      end

      if (w_clk_fall) begin
        r_psx_clk <= 1'b0;
        r_cmd     <= w_cmd_byte[w_nbit];
        r_bit     <= w_nbit;
        r_byte    <= w_nbyte;
      end
      // Received bits enter at the bottom, so the first one ends in bit 7.
      if (w_clk_rise) begin
        r_psx_clk <= 1'b1;
        r_rx      <= {r_rx[6:0], pad.data};
      end

      if (r_state == S_SHIFT && w_byte_end && r_byte == 3'd3) r_b3 <= r_rx;

      if (w_success) begin
        r_btn[r_port]  <= {r_b3, r_rx};
        r_conn[r_port] <= 1'b1;
        r_upd[r_port]  <= 1'b1;
      end
      if (w_abort) begin
        r_btn[r_port]  <= 16'hffff;
        r_conn[r_port] <= 1'b0;
      end

      if (r_state == S_RELEASE) begin
        r_att     <= 2'b11;
        r_cmd     <= 1'b1;
        r_psx_clk <= 1'b1;
      end
    end
  end

  assign pad.psx_clk       = r_psx_clk;
  assign pad.cmd           = r_cmd;
  assign pad.att           = r_att;
  assign o_button_state_0  = r_btn[0];
  assign o_button_state_1  = r_btn[1];
  assign o_connected       = r_conn;
  assign o_update          = r_upd;
endmodule

// File: tb/tb_psx_port_scheduler.sv
// Bench for psx_port_scheduler: two behavioural pads on the shared bus,
// expected transaction outcomes queued per poll and checked when ATT rises.
module tb_psx_port_scheduler;
  localparam int BOOT  = 100;
  localparam int HB    = 4;
  localparam int SETUP = 40;
  localparam int ACKTO = 120;
  localparam int BGAP  = 14;
  localparam int PGAP  = 250;
  localparam int BYTEC = 16 * HB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  enable = 2'b01;
  logic [15:0] bs0, bs1;
  logic [1:0]  conn, upd;

  psx_port_scheduler_if bus();

  psx_port_scheduler #(
    .BOOT_TIME(BOOT), .HALF_BIT(HB), .ATT_SETUP(SETUP),
    .ACK_TIMEOUT(ACKTO), .BYTE_GAP(BGAP), .PORT_GAP(PGAP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .pad(bus.master),
    .o_button_state_0(bs0), .o_button_state_1(bs1),
    .o_connected(conn), .o_update(upd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pad configuration
  logic [7:0] pad_tx [2][5];
  bit         present [2];
  int         ack_dly [2];

  typedef struct {
    int          port;
    bit          ok;
    logic [15:0] btn;
    int          low;
    int          falls;
    int          gap;   // 0 = do not check
  } txn_t;
  txn_t sb[$];

  function automatic txn_t exp_txn(input int p, input int gap);
    txn_t t;
    t.port = p; t.gap = gap; t.ok = 1'b0; t.btn = 16'hffff;
    if (!present[p]) begin
      t.low = SETUP + BYTEC + ACKTO + 1; t.falls = 8;
    end else if (pad_tx[p][2] != 8'h5A) begin
      t.low = SETUP + BYTEC + 2 * (ack_dly[p] + BGAP + BYTEC) + 1; t.falls = 24;
    end else begin
      t.ok = 1'b1; t.btn = {pad_tx[p][3], pad_tx[p][4]};
      t.low = SETUP + BYTEC + 4 * (ack_dly[p] + BGAP + BYTEC) + 1; t.falls = 40;
    end
    return t;
  endfunction

  task automatic expect_txn(input int p, input int gap);
    sb.push_back(exp_txn(p, gap));
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin @(negedge clk); n++; end
    chk("sb_drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Pad model: data changes on psx_clk fall, cmd captured on rise, one-cycle
  // ack pulse landing ack_dly cycles into the console's wait window.
  bit   pad_active;
  int   pad_port, pad_byte;
  initial begin
    int bit_i, cd;
    logic pc;
    logic [7:0] rxc, txb, expc;
    bus.data = 1'b1; bus.ack = 1'b1;
    pad_active = 1'b0; pad_port = 0; pad_byte = 0;
    bit_i = 0; cd = 0; pc = 1'b1; rxc = '0;
    forever begin
      @(negedge clk);
      if (bus.ack == 1'b0) bus.ack = 1'b1;
      if (cd > 0) begin cd--; if (cd == 0) bus.ack = 1'b0; end
      if (bus.att == 2'b11) begin
        pad_active = 1'b0; bus.data = 1'b1; cd = 0;
      end else begin
        if (!pad_active) begin
          pad_active = 1'b1; pad_port = bus.att[0] ? 1 : 0; pad_byte = 0; bit_i = 0;
        end
        if (pc && !bus.psx_clk && pad_byte < 5) begin
          txb = pad_tx[pad_port][pad_byte];
          bus.data = txb[3'(7 - bit_i)];
        end
        if (!pc && bus.psx_clk) begin
          rxc[3'(bit_i)] = bus.cmd;
          if (bit_i == 7) begin
            expc = (pad_byte == 0) ? 8'h01 : (pad_byte == 1) ? 8'h42 : 8'h00;
            chk($sformatf("cmd_p%0d_b%0d", pad_port, pad_byte), 32'(rxc), 32'(expc));
            if (present[pad_port] && pad_byte < 4) cd = HB + ack_dly[pad_port] - 1;
            pad_byte++; bit_i = 0;
          end else bit_i++;
        end
      end
      pc = bus.psx_clk;
    end
  end

  // Monitor: measures each ATT-low window and checks it against the scoreboard.
  bit overlap = 1'b0;
  initial begin
    logic [1:0] pa;
    logic pcm, rst_seen, oc;
    logic [15:0] ob;
    int low_n, falls_n, upd_n, high_n, mp;
    txn_t e;
    pa = 2'b11; pcm = 1'b1; rst_seen = 1'b0; oc = 1'b0; ob = '0;
    low_n = 0; falls_n = 0; upd_n = 0; high_n = 0; mp = 0;
    forever begin
      @(negedge clk);
      if (bus.att == 2'b00) overlap = 1'b1;
      if (rst) rst_seen = 1'b1;
      if (pa == 2'b11 && bus.att != 2'b11) begin
        mp = bus.att[0] ? 1 : 0;
        if (sb.size() > 0 && sb[0].gap != 0) chk("att_gap", 32'(high_n), 32'(sb[0].gap));
        low_n = 0; falls_n = 0; upd_n = 0; high_n = 0; rst_seen = rst;
        ob = mp ? bs0 : bs1; oc = mp ? conn[0] : conn[1];
      end
      if (bus.att != 2'b11) begin
        low_n++;
        if (pcm && !bus.psx_clk) falls_n++;
        if (upd[mp]) upd_n++;
      end else high_n++;
      if (pa != 2'b11 && bus.att == 2'b11 && !rst_seen) begin
        chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("txn_port", 32'(mp), 32'(e.port));
          chk("txn_connected", 32'(conn[mp]), 32'(e.ok));
          chk("txn_buttons", 32'(mp ? bs1 : bs0), 32'(e.btn));
          chk("txn_update_cnt", 32'(upd_n), 32'(e.ok ? 1 : 0));
          chk("txn_att_low_cycles", 32'(low_n), 32'(e.low));
          chk("txn_psx_clk_falls", 32'(falls_n), 32'(e.falls));
          chk("other_port_btn_hold", 32'(mp ? bs0 : bs1), 32'(ob));
          chk("other_port_conn_hold", 32'(mp ? conn[0] : conn[1]), 32'(oc));
        end
      end
      pa = bus.att; pcm = bus.psx_clk;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_att"}, 32'(bus.att), 32'h3);
    chk({tag, "_psx_clk"}, 32'(bus.psx_clk), 32'd1);
    chk({tag, "_cmd"}, 32'(bus.cmd), 32'd1);
    chk({tag, "_bs0"}, 32'(bs0), 32'hffff);
    chk({tag, "_bs1"}, 32'(bs1), 32'hffff);
    chk({tag, "_conn"}, 32'(conn), 32'd0);
    chk({tag, "_upd"}, 32'(upd), 32'd0);
  endtask

  task automatic boot_measure(input logic [1:0] exp_att);
    int n;
    n = 0;
    while (bus.att == 2'b11 && n < BOOT + 50) begin @(negedge clk); n++; end
    chk("boot_cycles", 32'(n), 32'(BOOT + 1));
    chk("boot_att", 32'(bus.att), 32'(exp_att));
  endtask

  initial begin
    int n, lowc;
    logic [15:0] held1;
    pad_tx[0] = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F};
    pad_tx[1] = '{8'hFF, 8'h73, 8'h5A, 8'h12, 8'h34};
    present[0] = 1'b1; present[1] = 1'b1;
    ack_dly[0] = 10;   ack_dly[1] = 1;

    // Reset values, then single-port poll of pad 0
    rst = 1'b1; enable = 2'b01;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    expect_txn(0, 0);
    rst = 1'b0;
    boot_measure(2'b10);
    drain(1500);

    // Both ports, alternating; pad 1 acks on its first wait cycle
    enable = 2'b11;
    pad_tx[0][3] = 8'hA5; pad_tx[0][4] = 8'hC3;
    expect_txn(1, PGAP + 1); expect_txn(0, PGAP + 1);
    expect_txn(1, PGAP + 1); expect_txn(0, PGAP + 1);
    drain(4000);

    // Pad 1 silent (ack timeout); pad 0 acks at the last allowed cycle
    present[1] = 1'b0; ack_dly[0] = ACKTO;
    expect_txn(1, PGAP + 1); expect_txn(0, PGAP + 1);
    drain(3000);

    // Pad 1 back
    present[1] = 1'b1; ack_dly[0] = 10;
    pad_tx[1][3] = 8'h3C; pad_tx[1][4] = 8'h96;
    expect_txn(1, PGAP + 1); expect_txn(0, PGAP + 1);
    drain(3000);

    // Port 1 disabled, pad 0 returns a bad sync byte
    enable = 2'b01;
    pad_tx[0][2] = 8'h00;
    expect_txn(0, PGAP + 1);
    drain(2000);
    held1 = {pad_tx[1][3], pad_tx[1][4]};
    chk("disabled_conn", 32'(conn), 32'd0);
    chk("disabled_bs1_hold", 32'(bs1), 32'(held1));
    pad_tx[0][2] = 8'h5A; pad_tx[0][3] = 8'h12; pad_tx[0][4] = 8'h34;
    expect_txn(0, PGAP + 1);
    drain(2000);

    // Reset during byte 3 of the next port 0 poll
    n = 0;
    while (!(pad_active && pad_port == 0 && pad_byte == 3 && bus.psx_clk == 1'b0) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("reach_byte3", 32'(n < 2000), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    enable = 2'b10;
    pad_tx[1][3] = 8'hDE; pad_tx[1][4] = 8'hAD;
    expect_txn(1, 0);
    rst = 1'b0;
    boot_measure(2'b01);
    drain(1500);

    // No port enabled: bus stays idle, port 1 loses connected
    enable = 2'b00;
    lowc = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (bus.att != 2'b11) lowc++;
    end
    chk("idle_att_low_cycles", 32'(lowc), 32'd0);
    chk("idle_conn", 32'(conn), 32'd0);
    chk("idle_bs1_hold", 32'(bs1), 32'hDEAD);

    // Only port 1 re-enabled
    enable = 2'b10;
    pad_tx[1][3] = 8'hBE; pad_tx[1][4] = 8'hEF;
    expect_txn(1, 0);
    drain(1500);

    chk("att_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
